// File: rtl/mmio_io_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_io_ctrl
//
// Memory-mapped I/O controller sitting beside data memory on the CPU's
// data path. It decodes a 32-byte window at BASE_ADDR and provides:
//   - RW output registers driving the seven-segment digits (HEX), the red
//     LEDs (LEDR) and the green LEDs (LEDG);
//   - RO views of the debounced pushbuttons (KEY, 1 = pressed) and switches (SW);
//   - sticky write-1-to-clear capture registers for key presses (KEYCAP)
//     and switch changes (SWCAP).
//
// Register map (addr[4:2], addr[1:0] ignored, full-word accesses):
//   0x00 HEX    RW  4 bits per digit
//   0x04 LEDR   RW
//   0x08 LEDG   RW
//   0x10 KEY    RO  debounced, 1 = pressed
//   0x14 SW     RO  debounced level
//   0x18 KEYCAP W1C sticky press flags
//   0x1C SWCAP  W1C sticky change flags
//   other offsets read as 0; writes to RO/unmapped offsets are dropped.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   addr     CPU byte address
//   wdata    CPU store data
//   we       store strobe, sampled on the rising edge of clk
//   rdata    combinational read data for addr
//   hit      combinational window decode; the CPU read mux selects rdata on hit
//   key_n    raw pushbuttons, active-low
//   sw       raw switches
//   hex_n    active-low segments, digit i at [7i+6:7i] (gfedcba order)
//   ledr     red LEDs
//   ledg     green LEDs
//
// Build option:
//   MMIO_IO_DEBOUNCE_EN  when defined, every KEY/SW bit has a counter-based
//                        debouncer (DEBOUNCE_CYCLES stable cycles to accept a
//                        change). When undefined, the debounced state is just
//                        the synchroniser output and DEBOUNCE_CYCLES is unused.
// -----------------------------------------------------------------------------
module mmio_io_ctrl #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] BASE_ADDR       = 32'hF0000000,
  parameter int               KEY_BITS        = 4,
  parameter int               SW_BITS         = 10,
  parameter int               HEX_DIGITS      = 4,
  parameter int               LEDR_BITS       = 10,
  parameter int               LEDG_BITS       = 8,
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        addr,
  input  logic [DBITS-1:0]        wdata,
  input  logic                    we,
  output logic [DBITS-1:0]        rdata,
  output logic                    hit,
  input  logic [KEY_BITS-1:0]     key_n,
  input  logic [SW_BITS-1:0]      sw,
  output logic [7*HEX_DIGITS-1:0] hex_n,
  output logic [LEDR_BITS-1:0]    ledr,
  output logic [LEDG_BITS-1:0]    ledg
);

  localparam int HEX_BITS = 4 * HEX_DIGITS;
  localparam int IN_BITS  = KEY_BITS + SW_BITS;

  localparam logic [2:0] OFF_HEX    = 3'd0;
  localparam logic [2:0] OFF_LEDR   = 3'd1;
  localparam logic [2:0] OFF_LEDG   = 3'd2;
  localparam logic [2:0] OFF_KEY    = 3'd4;
  localparam logic [2:0] OFF_SW     = 3'd5;
  localparam logic [2:0] OFF_KEYCAP = 3'd6;
  localparam logic [2:0] OFF_SWCAP  = 3'd7;

  logic [2:0]           offset;
  logic                 wr_en;

  logic [HEX_BITS-1:0]  hex_reg;
  logic [LEDR_BITS-1:0] ledr_reg;
  logic [LEDG_BITS-1:0] ledg_reg;

  logic [IN_BITS-1:0]   raw_in;
  logic [IN_BITS-1:0]   sync1;
  logic [IN_BITS-1:0]   sync2;
  logic [IN_BITS-1:0]   deb;
  logic [IN_BITS-1:0]   deb_prev;

  logic [KEY_BITS-1:0]  key_deb;
  logic [SW_BITS-1:0]   sw_deb;
  logic [KEY_BITS-1:0]  key_rise;
  logic [SW_BITS-1:0]   sw_chg;
  logic [KEY_BITS-1:0]  key_clr;
  logic [SW_BITS-1:0]   sw_clr;
  logic [KEY_BITS-1:0]  keycap;
  logic [SW_BITS-1:0]   swcap;

  // Only the word offset and the full store word matter; the byte lane bits
  // and the store bits above each register's width are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign hit    = (addr[DBITS-1:5] == BASE_ADDR[DBITS-1:5]);
  assign offset = addr[4:2];
  assign wr_en  = we & hit;

  // ---------------------------------------------------------------------------
  // RW output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_reg  <= '0;
      ledr_reg <= '0;
      ledg_reg <= '0;
    end else if (wr_en) begin
      case (offset)
        OFF_HEX:  hex_reg  <= wdata[HEX_BITS-1:0];
        OFF_LEDR: ledr_reg <= wdata[LEDR_BITS-1:0];
        OFF_LEDG: ledg_reg <= wdata[LEDG_BITS-1:0];
        default:  ;
      endcase
    end
  end

  assign ledr = ledr_reg;
  assign ledg = ledg_reg;

  // ---------------------------------------------------------------------------
  // Seven-segment decode (active-low, gfedcba)
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  for (genvar d = 0; d < HEX_DIGITS; d++) begin : g_hex
    assign hex_n[7*d +: 7] = hex_glyph(hex_reg[4*d +: 4]);
  end

  // ---------------------------------------------------------------------------
  // Input synchronisers. Keys are inverted first so that every bit of the
  // input path is active-high; KEY occupies the low bits, SW the high bits.
  // ---------------------------------------------------------------------------
  assign raw_in = {sw, ~key_n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

`ifdef MMIO_IO_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Per-bit debouncers. The counter restarts whenever the synchronised value
  // agrees with the debounced state, and also on the cycle in which the
  // synchronised value is about to change (sync1 != sync2), so any glitch
  // restarts the count. Counting starts on the first cycle sync2 holds the
  // new value; the accepting increment happens on the cycle that would bring
  // the count to DEBOUNCE_CYCLES, which gives exactly 2 + DEBOUNCE_CYCLES
  // edges from a raw change to the debounced register. The counter is
  // cleared on acceptance, so it never wraps.
  // ---------------------------------------------------------------------------
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  for (genvar b = 0; b < IN_BITS; b++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             deb_bit;

    assign cnt_next = cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt     <= '0;
        deb_bit <= 1'b0;
      end else if ((sync2[b] == deb_bit) || (sync1[b] != sync2[b])) begin
        cnt <= '0;
      end else if (cnt_next == CNT_MAX) begin
        deb_bit <= sync2[b];
        cnt     <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end

    assign deb[b] = deb_bit;
  end
`else
  // Without the debouncer the synchroniser output is the debounced state.
  assign deb = sync2;
`endif

  assign key_deb = deb[KEY_BITS-1:0];
  assign sw_deb  = deb[IN_BITS-1:KEY_BITS];

  // ---------------------------------------------------------------------------
  // Capture registers. Edges are detected against the previous debounced
  // state, so a flag becomes visible one cycle after the debounced change.
  // A set in the same cycle as a W1C clear wins because it is OR-ed in
  // after the clear mask is applied.
  // ---------------------------------------------------------------------------
  assign key_rise = key_deb & ~deb_prev[KEY_BITS-1:0];
  assign sw_chg   = sw_deb ^ deb_prev[IN_BITS-1:KEY_BITS];

  assign key_clr = (wr_en && (offset == OFF_KEYCAP)) ? wdata[KEY_BITS-1:0] : '0;
  assign sw_clr  = (wr_en && (offset == OFF_SWCAP))  ? wdata[SW_BITS-1:0]  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_prev <= '0;
      keycap   <= '0;
      swcap    <= '0;
    end else begin
      deb_prev <= deb;
      keycap   <= (keycap & ~key_clr) | key_rise;
      swcap    <= (swcap  & ~sw_clr)  | sw_chg;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: purely combinational, so a load in the same cycle as a store
  // returns the value from before that store. Narrow registers zero-extend.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_HEX:    rdata[HEX_BITS-1:0]  = hex_reg;
      OFF_LEDR:   rdata[LEDR_BITS-1:0] = ledr_reg;
      OFF_LEDG:   rdata[LEDG_BITS-1:0] = ledg_reg;
      OFF_KEY:    rdata[KEY_BITS-1:0]  = key_deb;
      OFF_SW:     rdata[SW_BITS-1:0]   = sw_deb;
      OFF_KEYCAP: rdata[KEY_BITS-1:0]  = keycap;
      OFF_SWCAP:  rdata[SW_BITS-1:0]   = swcap;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_io_ctrl
//
// Directed self-checking bench for mmio_io_ctrl with DEBOUNCE_CYCLES = 4.
// Expected values are hand-computed constants; the input-path latency is
// 2 + DEBOUNCE_CYCLES with MMIO_IO_DEBOUNCE_EN defined, 2 otherwise.
// -----------------------------------------------------------------------------
module tb_mmio_io_ctrl;

  localparam int DEB = 4;
`ifdef MMIO_IO_DEBOUNCE_EN
  localparam int LAT    = 2 + DEB;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit DEB_ON = 1'b0;
`endif
  localparam logic [31:0] BASE  = 32'hF0000000;
  localparam logic [27:0] HEX0S = {4{7'b1000000}};

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        hit;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [27:0] hex_n;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  int tests_run = 0;
  int tests_failed = 0;

  mmio_io_ctrl #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .hit   (hit),
    .key_n (key_n),
    .sw    (sw),
    .hex_n (hex_n),
    .ledr  (ledr),
    .ledg  (ledg)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the sequence stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance n clock edges, leaving time 1 ns past the last rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One store cycle: drive the bus, take one edge, then drop the strobe
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step(1);
    we    = 1'b0;
    wdata = '0;
  endtask

  // Combinational read of one address
  task automatic readReg(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    we   = 1'b0;
    #1;
    d = rdata;
  endtask

  // Main directed sequence
  initial begin
    logic [31:0] rd;

    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    key_n = 4'hF;
    sw    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of registers and outputs
    readReg(BASE + 32'h00, rd); checkOutput("rst_hex", rd, 32'h0);
    readReg(BASE + 32'h04, rd); checkOutput("rst_ledr", rd, 32'h0);
    readReg(BASE + 32'h08, rd); checkOutput("rst_ledg", rd, 32'h0);
    readReg(BASE + 32'h18, rd); checkOutput("rst_keycap", rd, 32'h0);
    checkOutput("rst_hex_n", {4'h0, hex_n}, {4'h0, HEX0S});
    step(1);

    // HEX glyphs A,b,C,d and readback
    applyStimulus(BASE + 32'h00, 32'h0000ABCD);
    checkOutput("hex_n_abcd", {4'h0, hex_n}, {4'h0, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001});
    readReg(BASE + 32'h00, rd); checkOutput("hex_rd_abcd", rd, 32'h0000ABCD);

    // Upper store bits are dropped; digits 0,F,8,0
    applyStimulus(BASE + 32'h00, 32'hFFFF0F80);
    checkOutput("hex_n_0f80", {4'h0, hex_n}, {4'h0, 7'b1000000, 7'b0001110, 7'b0000000, 7'b1000000});
    readReg(BASE + 32'h00, rd); checkOutput("hex_rd_0f80", rd, 32'h00000F80);

    // Store to the read-only KEY register is ignored
    applyStimulus(BASE + 32'h10, 32'h0000000F);
    readReg(BASE + 32'h10, rd); checkOutput("key_ro", rd, 32'h0);

    // LEDR / LEDG load their low bits
    applyStimulus(BASE + 32'h04, 32'hFFFFFD55);
    checkOutput("ledr_out", {22'h0, ledr}, 32'h155);
    readReg(BASE + 32'h04, rd); checkOutput("ledr_rd", rd, 32'h155);
    applyStimulus(BASE + 32'h08, 32'h000001A5);
    checkOutput("ledg_out", {24'h0, ledg}, 32'hA5);

    // Stores outside the window do nothing
    applyStimulus(32'hF0000024, 32'h000002AA);
    checkOutput("miss_hit_f20", {31'h0, hit}, 32'h0);
    checkOutput("miss_ledr_f20", {22'h0, ledr}, 32'h155);
    applyStimulus(32'hF0000020, 32'h00000000);
    readReg(BASE + 32'h00, rd); checkOutput("miss_hex_f20", rd, 32'h00000F80);
    applyStimulus(32'hE0000004, 32'h00000000);
    checkOutput("miss_hit_e00", {31'h0, hit}, 32'h0);
    checkOutput("miss_ledr_e00", {22'h0, ledr}, 32'h155);
    readReg(BASE + 32'h1C, rd); checkOutput("hit_top", {31'h0, hit}, 32'h1);

    // KEY[2] press: debounced after exactly LAT edges, captured one later
    key_n = 4'b1011;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      readReg(BASE + 32'h10, rd);
      checkOutput($sformatf("key2_lat_%0d", i), rd, (i == LAT) ? 32'h4 : 32'h0);
    end
    readReg(BASE + 32'h18, rd); checkOutput("keycap_early", rd, 32'h0);
    step(1);
    readReg(BASE + 32'h18, rd); checkOutput("keycap_set", rd, 32'h4);

    // Three-cycle glitch on KEY[1]: filtered by the debouncer, passed through without it
    key_n[1] = 1'b0;
    step(3);
    key_n[1] = 1'b1;
    step(LAT + 3);
    readReg(BASE + 32'h10, rd); checkOutput("glitch_key", rd, 32'h4);
    readReg(BASE + 32'h18, rd); checkOutput("glitch_keycap", rd, DEB_ON ? 32'h4 : 32'h6);
    applyStimulus(BASE + 32'h18, 32'h00000002);
    readReg(BASE + 32'h18, rd); checkOutput("w1c_bit1", rd, 32'h4);

    // Release KEY[2]: no capture on release
    key_n[2] = 1'b1;
    step(LAT + 2);
    readReg(BASE + 32'h10, rd); checkOutput("key2_released", rd, 32'h0);
    readReg(BASE + 32'h18, rd); checkOutput("keycap_hold", rd, 32'h4);

    // New press edge in the same cycle as a W1C clear: set wins
    key_n[2] = 1'b0;
    step(LAT);
    applyStimulus(BASE + 32'h18, 32'h00000004);
    readReg(BASE + 32'h18, rd); checkOutput("set_wins", rd, 32'h4);
    applyStimulus(BASE + 32'h18, 32'h00000004);
    readReg(BASE + 32'h18, rd); checkOutput("w1c_clear", rd, 32'h0);

    // Switches: level after LAT edges, change flags one later, unaligned address
    sw = 10'h2A5;
    step(LAT - 1);
    readReg(BASE + 32'h14, rd); checkOutput("sw_early", rd, 32'h0);
    step(1);
    readReg(BASE + 32'h14, rd); checkOutput("sw_level", rd, 32'h2A5);
    step(1);
    readReg(BASE + 32'h1C, rd); checkOutput("swcap_set", rd, 32'h2A5);
    readReg(32'hF0000016, rd); checkOutput("sw_unaligned", rd, 32'h2A5);
    applyStimulus(BASE + 32'h1C, 32'h000000A0);
    readReg(BASE + 32'h1C, rd); checkOutput("swcap_w1c", rd, 32'h205);

    // Reset in the middle of a KEY[0] debounce clears everything at once
    key_n = 4'b1110;
    step(5);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_hex_n", {4'h0, hex_n}, {4'h0, HEX0S});
    checkOutput("mid_rst_ledr", {22'h0, ledr}, 32'h0);
    checkOutput("mid_rst_ledg", {24'h0, ledg}, 32'h0);
    readReg(BASE + 32'h10, rd); checkOutput("mid_rst_key", rd, 32'h0);
    readReg(BASE + 32'h18, rd); checkOutput("mid_rst_keycap", rd, 32'h0);
    readReg(BASE + 32'h1C, rd); checkOutput("mid_rst_swcap", rd, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Full latency applies again after reset release
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      readReg(BASE + 32'h10, rd);
      checkOutput($sformatf("key0_post_rst_%0d", i), rd, (i == LAT) ? 32'h1 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Memory-mapped I/O controller for the processor's data-memory path. It decodes a 32-byte address window and holds the output registers for the HEX, LEDR and LEDG displays, with parametrised widths for all channels. KEY and SW inputs are synchronised and debounced, and press/change events are latched in sticky write-1-to-clear capture registers. It sits beside data memory, and the CPU read mux selects `rdata` whenever `hit` is high.

## Interface
- `DBITS`, 32, data/address width
- `BASE_ADDR`, 32'hF0000000, window base; must be 32-byte aligned
- `KEY_BITS`, 4, number of pushbuttons
- `SW_BITS`, 10, number of switches
- `HEX_DIGITS`, 4, number of seven-segment digits; 1..8
- `LEDR_BITS`, 10, red LED count
- `LEDG_BITS`, 8, green LED count
- `DEBOUNCE_CYCLES`, 500000, stable cycles required to accept an input change; ≥1
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `addr` in DBITS: byte address from the CPU
- `wdata` in DBITS: store data
- `we` in 1: store strobe, sampled on the rising edge of `clk`
- `rdata` out DBITS: combinational read data for `addr`
- `hit` out 1: combinational; `addr[DBITS-1:5] == BASE_ADDR[DBITS-1:5]`
- `key_n` in KEY_BITS: raw pushbuttons, active-low
- `sw` in SW_BITS: raw switches
- `hex_n` out 7*HEX_DIGITS: segments, active-low; digit i occupies `[7i+6:7i]`
- `ledr` out LEDR_BITS: red LEDs
- `ledg` out LEDG_BITS: green LEDs

## Operation
- Register offsets use `addr[4:2]`; `addr[1:0]` is ignored and all accesses are full-word.
  - 0x00 HEX: RW, 4 bits per digit, `4*HEX_DIGITS` bits wide.
  - 0x04 LEDR: RW.
  - 0x08 LEDG: RW.
  - 0x10 KEY: RO, debounced, 1 = pressed.
  - 0x14 SW: RO, debounced level.
  - 0x18 KEYCAP: W1C, sticky press flags.
  - 0x1C SWCAP: W1C, sticky change flags.
  - Other offsets read 0.
- Reads zero-extend into DBITS. Writes to RO or unmapped offsets are ignored. Writes with `hit`=0 are ignored.
- RW registers load `wdata` (low bits only) on a clock edge when `we` and `hit` are both high.
- HEX decode: each nibble drives its digit through the standard hex font (0-F), active-low. Example: 0 → 7'b1000000, 8 → 7'b0000000.
- Input path, per bit: inverter (KEY only) → 2-flop synchroniser → debouncer → debounced state register.
- Debouncer:
  - The counter clears whenever the synchronised value equals the debounced state, or when the synchronised value changes.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES`, the debounced state takes the synchronised value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter never wraps.
- KEYCAP[i] sets on a debounced 0→1 transition of KEY[i].
- SWCAP[i] sets on any debounced transition of SW[i].
- W1C: writing 1 clears the corresponding bit. If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset (asynchronous, immediate) values:
  - HEX register: 0, so `hex_n` = 7'b1000000 per digit.
  - LEDR, LEDG: 0.
  - Synchronisers, debounced states, counters, KEYCAP, SWCAP: 0.
- Store → output: the register and `ledr`/`ledg`/`hex_n` update on the `we` edge and are visible the next cycle.
- Read: `rdata` is a combinational function of `addr` and the current registers. A load in the same cycle as a store sees the old value.
- Raw input change → debounced register: exactly `2 + DEBOUNCE_CYCLES` edges when the input is held stable.
- Debounced transition → capture flag visible: 1 cycle later.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach the debounced state.
- Switches held high through reset debounce to 1 after `2+DEBOUNCE_CYCLES` cycles and set SWCAP. This is intended.
- Reset asserted mid-debounce discards the count.

## Configuration
- `MMIO_IO_DEBOUNCE_EN`
  - Defined: the debouncer is present as described.
  - Undefined: the debounced state equals the synchroniser output, latency is 2 cycles, and no counters are synthesised. `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Bench uses `DEBOUNCE_CYCLES`=4 and defaults otherwise.
- Reset, then read 0x00/0x04/0x08/0x18 → 0. `hex_n` = {4{7'b1000000}}.
- Store 0x0000ABCD to BASE+0x00 → next cycle `hex_n` digits 3..0 = A,b,C,d glyphs. Readback = 0x0000ABCD. Store to BASE+0x10 → KEY unchanged.
- Drive `key_n[2]`=0 steady → KEY read shows 0x4 after exactly 6 cycles and KEYCAP=0x4 one cycle later. Pulse `key_n[1]` low for 3 cycles → no change.
- KEYCAP=0x4, then store 0x4 to 0x18 in the same cycle a new KEY[2] press edge occurs → KEYCAP stays 0x4. Store 0x4 again → 0.
- `addr`=0xF0000020 or 0xE0000000 with `we` → `hit`=0, no register changes. `addr`=0xF0000016 → reads SW.
- Assert `reset` mid-debounce (count 3) → all state 0 immediately. After release, the full 6-cycle latency applies again.
